// File: rtl/tone_playback_ctrl.sv
// tone_playback_ctrl
// Plays a tone out of a signed sine-sample ROM. Once a command is accepted it
// issues one ROM read every DIV clocks, stepping the phase by a programmable
// increment (wrapping modulo DEPTH), and forwards each returned sample with a
// valid strobe. Several pitches come out of one table by varying the step.
//
// Optional feature macro: TONE_ATTEN_EN
//   Adds a 2-bit 'atten' input, latched at command accept. Each sample is then
//   arithmetically right-shifted by that amount (sign preserved).
//
// Ports
//   clk          : single clock, all logic on posedge
//   rst          : synchronous, active-high reset
//   start        : command strobe, accepted only when idle and not aborting
//   step         : phase increment per sample (0..15), latched at accept
//   length       : number of samples to play, latched at accept
//   abort        : cancels playback (and blocks a same-cycle start when idle)
//   atten        : sample attenuation shift (TONE_ATTEN_EN builds only)
//   rom_data     : signed ROM read data, valid one cycle after rom_en
//   rom_en       : ROM read enable
//   rom_addr     : ROM read address, holds its last value while rom_en is low
//   sample_out   : captured sample, holds between valids
//   sample_valid : sample_out is valid this cycle
//   busy         : playback in progress
//   done         : one-cycle pulse on normal completion
module tone_playback_ctrl #(
  parameter int DEPTH  = 252,
  parameter int ADDR_W = 8,
  parameter int DIV    = 100,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               step,
  input  logic [15:0]              length,
  input  logic                     abort,
`ifdef TONE_ATTEN_EN
  input  logic [1:0]               atten,
`endif
  input  logic signed [DATA_W-1:0] rom_data,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   phase_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          step_q;
  logic [15:0]         count_q;
  logic [DIV_W-1:0]    div_q;
  logic                vld_p1;
  logic                done_q;
  logic signed [DATA_W-1:0] hold_p1;
  logic signed [DATA_W-1:0] shaped_p1;
  logic                tick;
  logic                accept;
  logic                last_read;
`ifdef TONE_ATTEN_EN
  logic [1:0]          atten_q;
`endif

  // Phase advance: the sum is formed one bit wider than the address so that
  // phase+step never overflows before the wrap comparison against DEPTH.
  function automatic logic [ADDR_W-1:0] wrap_phase(input logic [ADDR_W-1:0] ph,
                                                   input logic [3:0]        st);
    logic [ADDR_W:0] sum;
    sum = {1'b0, ph} + (ADDR_W + 1)'(st);
    if (sum >= DEPTH_X) begin
      sum = sum - DEPTH_X;
    end
    return sum[ADDR_W-1:0];
  endfunction

`ifdef TONE_ATTEN_EN
  function automatic logic signed [DATA_W-1:0] shape(input logic signed [DATA_W-1:0] d,
                                                     input logic [1:0]               sh);
    return d >>> sh;
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] shape(input logic signed [DATA_W-1:0] d);
    return d;
  endfunction
`endif

  assign tick      = (state_q == PLAY) && (div_q == '0);
  assign accept    = (state_q == IDLE) && start && !abort;
  assign last_read = tick && (count_q == 16'd1);

  always_comb begin
    state_d  = state_q;
    rom_en   = 1'b0;
    rom_addr = addr_q;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (length != '0)) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        busy   = 1'b1;
        rom_en = tick;
        if (tick) begin
          rom_addr = phase_q;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (last_read) begin
          state_d = LAST;
        end
      end
      LAST: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      step_q  <= '0;
      count_q <= '0;
      div_q   <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      hold_p1 <= '0;
`ifdef TONE_ATTEN_EN
      atten_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      // A read issued this cycle returns data next cycle; abort drops it.
      vld_p1  <= tick && !abort;
      // done fires either for a zero-length command (no reads at all) or as
      // the final read leaves PLAY for LAST.
      done_q  <= (accept && (length == '0)) ||
                 (state_q == PLAY && last_read && !abort);
      if (vld_p1) begin
        hold_p1 <= shaped_p1;
      end
      if (accept) begin
        step_q  <= step;
        count_q <= length;
        phase_q <= '0;
        div_q   <= '0;
`ifdef TONE_ATTEN_EN
        atten_q <= atten;
`endif
      end else if (state_q == PLAY) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (tick) begin
          addr_q  <= phase_q;
          phase_q <= wrap_phase(phase_q, step_q);
          count_q <= count_q - 16'd1;
        end
      end
    end
  end

  // ---- stage p1: ROM data returns; present it with the valid strobe ----
`ifdef TONE_ATTEN_EN
  assign shaped_p1 = shape(rom_data, atten_q);
`else
  assign shaped_p1 = shape(rom_data);
`endif

  assign sample_out   = vld_p1 ? shaped_p1 : hold_p1;
  assign sample_valid = vld_p1;
  assign done         = done_q;

endmodule
